ps2_command_sequencer: RTL and testbench

// - Host-side controller for the PS/2 receive and transmit engines: accepts one command per request,

---
 rtl/ps2_command_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ps2_command_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_sequencer.sv
// ps2_command_sequencer: PS/2 host command/ACK sequencer with resend, ACK timeout and idle byte forwarding.
// Define PS2_CMD_ARG_EN to add the argument byte phase (SEND_ARG / WAIT_ARG_ACK).
module ps2_command_sequencer #(
  parameter logic [19:0] ACK_TIMEOUT = 20'd1000000,
  parameter logic [7:0]  MAX_RETRIES = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid_i,
  input  logic [7:0] cmd_byte_i,
  input  logic [7:0] cmd_arg_i,
  input  logic       cmd_has_arg_i,
  output logic       cmd_ready_o,
  output logic       resp_valid_o,
  output logic [1:0] resp_status_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic [7:0] the_command_o,
  output logic       send_command_o,
  input  logic       command_was_sent_i,
  input  logic       error_communication_timed_out_i,
  output logic       wait_for_incoming_data_o,
  input  logic [7:0] received_data_i,
  input  logic       received_data_en_i
);
  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_ACK, DONE
`ifdef PS2_CMD_ARG_EN
    , SEND_ARG, WAIT_ARG_ACK
`endif
  } state_t;
  state_t      state_q;
  logic [7:0]  retries_q;
  logic [19:0] timer_q;
  logic        rx_en_q;
  logic [7:0]  rx_data_q;
`ifdef PS2_CMD_ARG_EN
  logic [7:0]  arg_q;
  logic        has_arg_q;
`else
  logic        unused_arg;
  assign unused_arg = ^{cmd_arg_i, cmd_has_arg_i};
`endif
  // ACK/NACK bytes are evaluated one cycle after arrival, giving a two-cycle ACK-to-response latency
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                  <= IDLE;
      retries_q                <= '0;
      timer_q                  <= '0;
      rx_en_q                  <= 1'b0;
      rx_data_q                <= '0;
      cmd_ready_o              <= 1'b1;
      resp_valid_o             <= 1'b0;
      resp_status_o            <= 2'b00;
      rx_valid_o               <= 1'b0;
      rx_byte_o                <= '0;
      the_command_o            <= '0;
      send_command_o           <= 1'b0;
      wait_for_incoming_data_o <= 1'b1;
`ifdef PS2_CMD_ARG_EN
      arg_q                    <= '0;
      has_arg_q                <= 1'b0;
`endif
    end else begin
      resp_valid_o <= 1'b0;
      rx_valid_o   <= 1'b0;
      rx_en_q      <= received_data_en_i;
      rx_data_q    <= received_data_i;
      case (state_q)
        IDLE: begin
          if (received_data_en_i) begin
            rx_valid_o <= 1'b1;
            rx_byte_o  <= received_data_i;
          end
          if (cmd_valid_i) begin
            state_q                  <= SEND;
            cmd_ready_o              <= 1'b0;
            the_command_o            <= cmd_byte_i;
            send_command_o           <= 1'b1;
            wait_for_incoming_data_o <= 1'b0;
`ifdef PS2_CMD_ARG_EN
            arg_q                    <= cmd_arg_i;
            has_arg_q                <= cmd_has_arg_i;
`endif
          end
        end
`ifdef PS2_CMD_ARG_EN
        SEND, SEND_ARG: begin
`else
        SEND: begin
`endif
          if (error_communication_timed_out_i) begin
            state_q                  <= DONE;
            resp_valid_o             <= 1'b1;
            resp_status_o            <= 2'b11;
            send_command_o           <= 1'b0;
            wait_for_incoming_data_o <= 1'b1;
          end else if (command_was_sent_i) begin
`ifdef PS2_CMD_ARG_EN
            state_q                  <= (state_q == SEND) ? WAIT_ACK : WAIT_ARG_ACK;
`else
            state_q                  <= WAIT_ACK;
`endif
            send_command_o           <= 1'b0;
            wait_for_incoming_data_o <= 1'b1;
            timer_q                  <= '0;
          end
        end
`ifdef PS2_CMD_ARG_EN
        WAIT_ACK, WAIT_ARG_ACK: begin
`else
        WAIT_ACK: begin
`endif
          timer_q <= timer_q + 20'd1;
          if (rx_en_q && rx_data_q == 8'hFA) begin
`ifdef PS2_CMD_ARG_EN
            if (state_q == WAIT_ACK && has_arg_q) begin
              state_q                  <= SEND_ARG;
              the_command_o            <= arg_q;
              send_command_o           <= 1'b1;
              wait_for_incoming_data_o <= 1'b0;
            end else begin
              state_q       <= DONE;
              resp_valid_o  <= 1'b1;
              resp_status_o <= 2'b00;
            end
`else
            state_q       <= DONE;
            resp_valid_o  <= 1'b1;
            resp_status_o <= 2'b00;
`endif
          end else if (rx_en_q && rx_data_q == 8'hFE) begin
            if (retries_q == MAX_RETRIES) begin
              state_q       <= DONE;
              resp_valid_o  <= 1'b1;
              resp_status_o <= 2'b01;
            end else begin
              retries_q                <= retries_q + 8'd1;
`ifdef PS2_CMD_ARG_EN
              state_q                  <= (state_q == WAIT_ACK) ? SEND : SEND_ARG;
`else
              state_q                  <= SEND;
`endif
              send_command_o           <= 1'b1;
              wait_for_incoming_data_o <= 1'b0;
            end
          end else if (!rx_en_q && timer_q >= ACK_TIMEOUT - 20'd1) begin
            state_q       <= DONE;
            resp_valid_o  <= 1'b1;
            resp_status_o <= 2'b10;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cmd_ready_o <= 1'b1;
          retries_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_command_sequencer.sv
// tb_ps2_command_sequencer: directed self-checking bench for ps2_command_sequencer (ACK_TIMEOUT=16, MAX_RETRIES=3).
module tb_ps2_command_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic [7:0] cmd_byte_i = '0;
  logic [7:0] cmd_arg_i = '0;
  logic       cmd_has_arg_i = 1'b0;
  logic       cmd_ready_o;
  logic       resp_valid_o;
  logic [1:0] resp_status_o;
  logic       rx_valid_o;
  logic [7:0] rx_byte_o;
  logic [7:0] the_command_o;
  logic       send_command_o;
  logic       command_was_sent_i = 1'b0;
  logic       error_communication_timed_out_i = 1'b0;
  logic       wait_for_incoming_data_o;
  logic [7:0] received_data_i = '0;
  logic       received_data_en_i = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int n;
  int txn;

  ps2_command_sequencer #(.ACK_TIMEOUT(20'd16), .MAX_RETRIES(8'd3)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid_i(cmd_valid_i),
    .cmd_byte_i(cmd_byte_i),
    .cmd_arg_i(cmd_arg_i),
    .cmd_has_arg_i(cmd_has_arg_i),
    .cmd_ready_o(cmd_ready_o),
    .resp_valid_o(resp_valid_o),
    .resp_status_o(resp_status_o),
    .rx_valid_o(rx_valid_o),
    .rx_byte_o(rx_byte_o),
    .the_command_o(the_command_o),
    .send_command_o(send_command_o),
    .command_was_sent_i(command_was_sent_i),
    .error_communication_timed_out_i(error_communication_timed_out_i),
    .wait_for_incoming_data_o(wait_for_incoming_data_o),
    .received_data_i(received_data_i),
    .received_data_en_i(received_data_en_i)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {cmd_ready_o, send_command_o, wait_for_incoming_data_o, resp_valid_o, resp_status_o,
              rx_valid_o, rx_byte_o, the_command_o},
        {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00});
  endtask

  task automatic issue(input logic [7:0] b, input logic [7:0] a, input logic ha);
    cmd_valid_i = 1'b1; cmd_byte_i = b; cmd_arg_i = a; cmd_has_arg_i = ha;
    tick;
    cmd_valid_i = 1'b0; cmd_has_arg_i = 1'b0;
  endtask

  task automatic sent_pulse;
    command_was_sent_i = 1'b1;
    tick;
    command_was_sent_i = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    received_data_en_i = 1'b1; received_data_i = d;
    tick;
    received_data_en_i = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    chk_reset_outputs("reset_values");
    reset = 1'b0;
    tick;
    chk_reset_outputs("idle_after_reset");

    // F4 acknowledged
    issue(8'hF4, 8'h00, 1'b0);
    chk("f4_send", {cmd_ready_o, send_command_o, wait_for_incoming_data_o, the_command_o}, {3'b010, 8'hF4});
    tick;
    chk("f4_send_held", send_command_o, 1'b1);
    sent_pulse;
    chk("f4_wait_ack", {send_command_o, wait_for_incoming_data_o}, 2'b01);
    rx_pulse(8'hFA);
    chk("f4_ack_lat1", {resp_valid_o, rx_valid_o}, 2'b00);
    tick;
    chk("f4_resp", {resp_valid_o, resp_status_o, rx_valid_o, cmd_ready_o}, 5'b10000);
    tick;
    chk("f4_back_idle", {resp_valid_o, cmd_ready_o}, 2'b01);

    // FF NACKed four times: three resends, then status 01
    issue(8'hFF, 8'h00, 1'b0);
    txn = 0;
    for (int i = 0; i < 4; i++) begin
      if (send_command_o && the_command_o == 8'hFF) txn++;
      sent_pulse;
      rx_pulse(8'hFE);
      tick;
    end
    chk("ff_transmissions", txn, 4);
    chk("ff_nack_resp", {resp_valid_o, resp_status_o, send_command_o}, 4'b1010);
    tick;
    chk("ff_back_idle", cmd_ready_o, 1'b1);

    // F2 with no reply: timeout 16 clock edges after command_was_sent is sampled
    issue(8'hF2, 8'h00, 1'b0);
    sent_pulse;
    n = 0;
    while (!resp_valid_o && n < 40) begin
      tick;
      n++;
    end
    chk("f2_timeout_latency", n, 16);
    chk("f2_timeout_status", resp_status_o, 2'b10);
    tick;

    // unrelated byte during WAIT_ACK is dropped, retry counter was cleared so FE resends
    issue(8'hF3, 8'h00, 1'b0);
    sent_pulse;
    rx_pulse(8'hAA);
    tick;
    chk("ignored_byte", {rx_valid_o, resp_valid_o}, 2'b00);
    rx_pulse(8'hFE);
    tick;
    chk("resend_after_clear", {send_command_o, the_command_o}, {1'b1, 8'hF3});
    sent_pulse;
    rx_pulse(8'hFA);
    tick;
    chk("f3_resp", {resp_valid_o, resp_status_o}, 3'b100);
    tick;

    // ED: error and sent coincide, error wins
    issue(8'hED, 8'h00, 1'b0);
    chk("ed_send_wfid", wait_for_incoming_data_o, 1'b0);
    error_communication_timed_out_i = 1'b1;
    command_was_sent_i = 1'b1;
    tick;
    error_communication_timed_out_i = 1'b0;
    command_was_sent_i = 1'b0;
    chk("ed_err_resp", {resp_valid_o, resp_status_o, send_command_o, wait_for_incoming_data_o}, 5'b11101);
    tick;
    chk("ed_back_idle", {cmd_ready_o, wait_for_incoming_data_o, resp_valid_o}, 3'b110);

    // idle forwarding of scan codes
    received_data_en_i = 1'b1; received_data_i = 8'h1C;
    tick;
    chk("rx_1c", {rx_valid_o, rx_byte_o, cmd_ready_o}, {1'b1, 8'h1C, 1'b1});
    received_data_i = 8'hF0;
    tick;
    received_data_en_i = 1'b0;
    chk("rx_f0", {rx_valid_o, rx_byte_o, cmd_ready_o}, {1'b1, 8'hF0, 1'b1});
    tick;
    chk("rx_pulse_end", {rx_valid_o, cmd_ready_o}, 2'b01);

`ifdef PS2_CMD_ARG_EN
    // ED with argument 07: arg NACKed once, resent alone, then ACKed
    issue(8'hED, 8'h07, 1'b1);
    chk("arg_cmd_byte", {send_command_o, the_command_o}, {1'b1, 8'hED});
    sent_pulse;
    rx_pulse(8'hFA);
    tick;
    chk("arg_send", {send_command_o, the_command_o, resp_valid_o}, {1'b1, 8'h07, 1'b0});
    sent_pulse;
    rx_pulse(8'hFE);
    tick;
    chk("arg_resend", {send_command_o, the_command_o}, {1'b1, 8'h07});
    sent_pulse;
    rx_pulse(8'hFA);
    tick;
    chk("arg_resp", {resp_valid_o, resp_status_o}, 3'b100);
    tick;
`else
    // without the argument feature cmd_has_arg is ignored
    issue(8'hED, 8'h07, 1'b1);
    sent_pulse;
    rx_pulse(8'hFA);
    tick;
    chk("noarg_resp", {resp_valid_o, resp_status_o, the_command_o}, {3'b100, 8'hED});
    tick;
`endif

    // acceptance coincides with a received byte, then reset mid-WAIT_ACK
    cmd_valid_i = 1'b1; cmd_byte_i = 8'hF4;
    received_data_en_i = 1'b1; received_data_i = 8'h33;
    tick;
    cmd_valid_i = 1'b0; received_data_en_i = 1'b0;
    chk("accept_rx_fwd", {rx_valid_o, rx_byte_o, send_command_o}, {1'b1, 8'h33, 1'b1});
    sent_pulse;
    reset = 1'b1;
    tick;
    chk_reset_outputs("reset_mid_wait");
    reset = 1'b0;
    received_data_en_i = 1'b1; received_data_i = 8'hFA;
    tick;
    received_data_en_i = 1'b0;
    tick;
    chk("no_resp_after_reset", {resp_valid_o, cmd_ready_o, send_command_o}, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
